// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit producing HI/LO for the result mux.
// One shift-add or restoring-divide step per clock on operand magnitudes; signs are fixed up in FIN.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state, state_nxt;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic [WIDTH-1:0]     ma, mb, a_orig;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_nxt, prod_fix;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [WIDTH-1:0]     a_mag, b_mag, quo_fix, rem_fix;
  logic                 accept;

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && start && !flush;

  always_comb begin
    a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag = (op[0] && b[WIDTH-1]) ? -b : b;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
    if (is_div) begin
      if (!div_trial[WIDTH]) acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                   acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (flush)                   state_nxt = IDLE;
        else if (cnt == CNT_W'(1))   state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      ma      <= '0;
      mb      <= '0;
      a_orig  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div  <= op[1];
            neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= op[0] & a[WIDTH-1];
            ma      <= a_mag;
            mb      <= b_mag;
            a_orig  <= a;
            acc     <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            cnt     <= CNT_W'(WIDTH);
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIN: begin
          // Divide by zero reports all-ones quotient and the untouched dividend
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              if (mb == '0) begin
                lo <= '1;
                hi <= a_orig;
              end else begin
                lo <= quo_fix;
                hi <= rem_fix;
              end
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // {hi, lo} from plain 64-bit arithmetic; SV division truncates toward zero like the MDU
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = {32'b0, x} * {32'b0, y};
      2'b01: p = sx * sy;
      default: begin
        if (y == 32'd0)      p = {x, 32'hFFFF_FFFF};
        else if (o == 2'b10) p = {x % y, x / y};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic startOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic waitDone(input int from, output int lat);
    lat = from;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 60);
    checkOutput("done_seen", {63'b0, done}, 64'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [63:0] want);
    int lat;
    startOp(o, x, y);
    waitDone(0, lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'd33);
    checkOutput({tag, "_hilo"}, {hi, lo}, want);
    @(posedge clk);
    #1 checkOutput({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int lat;
    bit saw_done;
    logic [63:0] prev;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b1; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 32'h1; b = 32'h1; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    applyStimulus("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    applyStimulus("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("divu_small",2'b10, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
    applyStimulus("divu_zero", 2'b10, 32'h1234,      32'd0,         64'h0000_1234_FFFF_FFFF);
    applyStimulus("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    applyStimulus("div_zero",  2'b11, 32'hFFFF_FFF0, 32'd0,         64'hFFFF_FFF0_FFFF_FFFF);

    // start pulsed mid-CALC must not disturb the running multiply
    startOp(2'b00, 32'd1000, 32'd2000);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd9; op = 2'b10;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(10, lat);
    checkOutput("midstart_lat", 64'(lat), 64'd33);
    checkOutput("midstart_hilo", {hi, lo}, 64'd2_000_000);

    // new start accepted in the done cycle
    @(posedge clk); #1;
    startOp(2'b00, 32'd6, 32'd7);
    waitDone(0, lat);
    checkOutput("b2b_first", {hi, lo}, 64'd42);
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(0, lat);
    checkOutput("b2b_lat", 64'(lat), 64'd33);
    checkOutput("b2b_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // IDLE writes, then a write during CALC that must be dropped
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b1; wdata = 32'h5A5A_0001;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("idle_write", {hi, lo}, 64'h5A5A_0001_A5A5_A5A5);
    startOp(2'b00, 32'd3, 32'd5);
    @(negedge clk);
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 lo_we = 1'b0; hi_we = 1'b0;
    checkOutput("calc_write_ignored", {hi, lo}, 64'h5A5A_0001_A5A5_A5A5);
    waitDone(1, lat);
    checkOutput("calc_write_lat", 64'(lat), 64'd33);
    checkOutput("calc_write_hilo", {hi, lo}, 64'd15);

    // flush at CALC cycle 10
    @(posedge clk); #1;
    prev = {hi, lo};
    startOp(2'b10, 32'd999, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_busy", {63'b0, busy}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1 saw_done |= done; end
    checkOutput("flush_no_done", {63'b0, saw_done}, 64'd0);
    checkOutput("flush_hilo", {hi, lo}, prev);

    // reset in the middle of CALC discards the operation
    startOp(2'b01, 32'h1234_5678, 32'h8765_4321);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("midreset_busy", {63'b0, busy}, 64'd0);
    checkOutput("midreset_hilo", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1 saw_done |= done; end
    checkOutput("midreset_no_done", {63'b0, saw_done}, 64'd0);

    // random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom());
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : 32'($urandom());
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 30);
      applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, refModel(ro, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative 32-bit multiply/divide unit for the CPU datapath.
- Produces HI/LO result registers that feed the 8:1 32-bit write-back/result select mux; HI and LO occupy two of its eight inputs.
- Multi-cycle with a start/busy/done handshake. The controller stalls on busy and selects HI or LO at the mux once done.

Parameters:
- WIDTH, 32, operand and result-half width (only 32 is verified).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- flush  input  1  abort the in-flight operation.
- hi_we  input  1  write wdata into HI (MTHI).
- lo_we  input  1  write wdata into LO (MTLO).
- wdata  input  WIDTH  data for hi_we/lo_we.
- hi  output  WIDTH  HI register: product high half, or remainder.
- lo  output  WIDTH  LO register: product low half, or quotient.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo take a new result.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge) sets: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation; no done pulse.
- States: IDLE, CALC, FIN. busy = (state != IDLE). done is a registered output.
- IDLE:
  - start=1 at edge E0: latch op; latch |a| and |b| (magnitudes for signed ops); latch the result signs; counter=WIDTH; go to CALC.
  - start=0: hi_we/lo_we update hi/lo from wdata. Both may be set in the same cycle.
  - start and a write in the same cycle: start wins and the write is dropped.
- CALC: one iteration per edge on unsigned magnitudes; counter decrements. After WIDTH edges (E1..E32), go to FIN.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per iteration.
- FIN (edge E33): apply sign fixes, load hi/lo, done=1 for exactly one cycle, go to IDLE.
- Latency: done is visible in the cycle after E33, 33 clocks after the start edge. hi/lo hold the result until the next FIN, write, or reset.
- Back-to-back: start may be asserted in the cycle done is high; it is accepted at that edge.
- Ignored while busy: start, op, a, b, hi_we, lo_we. hi/lo never change in CALC.
- flush=1 in CALC or FIN: go to IDLE at that edge, no done, hi/lo unchanged. flush in IDLE has no effect. flush overrides start in the same cycle.
- MULT sign rule: 64-bit product negated (two's complement) if the signs of a and b differ.
- DIV sign rule:
  - quotient is negative if the operand signs differ; remainder takes the sign of the dividend.
  - Truncation toward zero.
- DIV(U) by zero: lo=all ones, hi=dividend (the original a). Still takes full latency with the normal done pulse.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm; no trap.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 -> hi=lo=0, busy=0, done=0. Deassert reset mid-CALC -> no done pulse ever.
- MULTU a=b=0xFFFFFFFF -> busy for 33 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001. MULT a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Divide by zero and overflow:
  - DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, latency 33.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake:
  - start pulsed mid-CALC with different operands -> ignored; result matches the first operands.
  - New start in the done cycle -> accepted; second done exactly 33 cycles later.
- Writes and flush:
  - lo_we=1 with wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5.
  - Same write during CALC -> ignored.
  - flush at CALC cycle 10 -> busy drops the next cycle, no done, hi/lo keep the prior values.
